vec_alu_engine: RTL and testbench
=================================

VEC_ALU_ENGINE -- requirements
Module: vec_alu_engine

Interface
REQ-001 Parameter DATA_W, default 32: element width in bits; SHALL be 8, 16, 32 or 64.
REQ-002 Parameter ADDR_W, default 14: byte-address width of the vector memory.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESET  input  1  reset; synchronous and active-high.
REQ-005 cmd  input  2  0=NOP, 1=ADD, 2=SUB, 3=ADDSAT (signed saturating add).
REQ-006 veca_addr, vecb_addr, vecr_addr  input  ADDR_W each  byte base addresses of A, B, R.
REQ-007 vec_len  input  ADDR_W+1  vector length in bytes.
REQ-008 status  output  3  0=waiting, 1=done, 5=adding, 6=error.
REQ-009 ovf_cnt  output  ADDR_W  count of elements with signed overflow in the last command.
REQ-010 mem_en, mem_we  output  1 each  memory port enable and write enable.
REQ-011 mem_addr  output  ADDR_W-log2(DATA_W/8)  word address (byte address >> log2(DATA_W/8)).
REQ-012 mem_wdata  output  DATA_W; mem_rdata  input  DATA_W, valid exactly one cycle after a read issue.

Function
REQ-013 FSM states: IDLE, RD_A, RD_B, WR_R, DONE, ERR.
REQ-014 In IDLE with cmd!=NOP: sample all address/length inputs and cmd; later input changes SHALL be ignored until IDLE.
REQ-015 Element count N = vec_len >> log2(DATA_W/8); trailing partial bytes are ignored.
REQ-016 N=0: go IDLE->DONE directly, no memory access.
REQ-017 Per element i: RD_A issues read at A+i; RD_B issues read at B+i and captures A data; WR_R computes from captured A and B data and writes R+i; exactly 3 cycles per element, no gaps.
REQ-018 After the last WR_R, next state is DONE; total latency from IDLE exit to status=done is 3*N+1 cycles.
REQ-019 Word addresses SHALL wrap modulo 2^(ADDR_W-log2(DATA_W/8)); no error on wrap.
REQ-020 ADD/SUB: result modulo 2^DATA_W; ADDSAT: clamp to signed max/min.
REQ-021 ovf_cnt increments on each element whose signed result overflows (before saturation); cleared on IDLE exit; saturates at all-ones.
REQ-022 status=5 in RD_A/RD_B/WR_R; 1 in DONE; 6 in ERR; 0 in IDLE.
REQ-023 DONE and ERR hold until cmd==NOP, then IDLE one cycle later; a new command requires at least one NOP cycle.
REQ-024 mem_en=1 only in RD_A, RD_B, WR_R; mem_we=1 only in WR_R.
REQ-025 R overlapping A or B: each element reads before it writes, so in-place (R==A) is correct.

Reset
REQ-026 ARESET=1 at any edge, including mid-vector: state IDLE, status=0, ovf_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; partially written R is not restored.
REQ-027 Reset SHALL dominate cmd on the same edge.

Configuration
REQ-028 Macro VEC_ALU_SAT_EN: when defined, ADDSAT behaves per REQ-020.
REQ-029 Without VEC_ALU_SAT_EN: cmd=3 in IDLE SHALL go to ERR with no memory access; ovf_cnt still counts for ADD/SUB.

Verification
REQ-030 DATA_W=32, A[1]=16 (byte 4), B[2]=32 (byte 8), R byte 16, vec_len=4, cmd=ADD -> mem word 4 = 48, status=1 after 4 cycles.
REQ-031 vec_len=0, cmd=SUB -> status=1 next cycle, mem_en never asserted, ovf_cnt=0.
REQ-032 A=0x7FFFFFFF, B=1, N=1: ADD -> R=0x80000000, ovf_cnt=1; ADDSAT (macro on) -> R=0x7FFFFFFF, ovf_cnt=1; macro off -> status=6.
REQ-033 ADDR_W=14, A base 0x3FFC, vec_len=8 -> second A read at word 0 (wrap).
REQ-034 ARESET asserted in cycle 5 of an N=8 ADD -> all outputs at reset values next cycle; following NOP then ADD completes correctly.
REQ-035 R==A, N=16, DATA_W=16, random signed A, B -> every R[i]=A[i]+B[i] mod 2^16 versus model.

Source files
------------

// File: rtl/vec_alu_engine_if.sv
// Memory port bundle for vec_alu_engine: the engine is the master, the vector memory the slave.
// Read data must be returned exactly one cycle after a read is issued.
interface vec_alu_engine_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
);
   localparam int WA = ADDR_W - $clog2(DATA_W / 8);

   logic              mem_en;
   logic              mem_we;
   logic [WA-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/vec_alu_engine.sv
// Element-wise vector ADD/SUB/ADDSAT engine over a single-port word memory, 3 cycles per element.
// Optional macro VEC_ALU_SAT_EN enables signed saturating add (cmd=3); without it cmd=3 raises an error.
module vec_alu_engine #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [1:0]        cmd,
   input  logic [ADDR_W-1:0] veca_addr,
   input  logic [ADDR_W-1:0] vecb_addr,
   input  logic [ADDR_W-1:0] vecr_addr,
   input  logic [ADDR_W:0]   vec_len,
   output logic [2:0]        status,
   output logic [ADDR_W-1:0] ovf_cnt,
   vec_alu_engine_if.master  mem
);
   localparam int SH = $clog2(DATA_W / 8);
   localparam int WA = ADDR_W - SH;
   localparam int NW = ADDR_W + 1 - SH;
   localparam int M  = DATA_W - 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD_A = 3'd1;
   localparam logic [2:0] S_RD_B = 3'd2;
   localparam logic [2:0] S_WR_R = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   localparam logic [1:0] CMD_NOP    = 2'd0;
   localparam logic [1:0] CMD_ADD    = 2'd1;
   localparam logic [1:0] CMD_SUB    = 2'd2;
   localparam logic [1:0] CMD_ADDSAT = 2'd3;

   logic [2:0]        state;
   logic [1:0]        cmd_q;
   logic [WA-1:0]     a_base, b_base, r_base;
   logic [NW-1:0]     n_q, idx;
   logic [DATA_W-1:0] a_q;

   logic [DATA_W-1:0] b_d, sum, diff, result;
   logic              ovf;
   logic [WA-1:0]     idx_w;
   logic [NW-1:0]     n_in;
   logic              unused_bits;

   // Only the word part of each byte address/length matters; low bytes are dropped.
   assign n_in        = vec_len[ADDR_W:SH];
   assign idx_w       = idx[WA-1:0];
   assign unused_bits = ^{veca_addr, vecb_addr, vecr_addr, vec_len};

   always_comb begin
      b_d    = mem.mem_rdata;
      sum    = a_q + b_d;
      diff   = a_q - b_d;
      result = sum;
      ovf    = (a_q[M] == b_d[M]) && (sum[M] != a_q[M]);
      case (cmd_q)
         CMD_SUB: begin
            result = diff;
            ovf    = (a_q[M] != b_d[M]) && (diff[M] != a_q[M]);
         end
`ifdef VEC_ALU_SAT_EN
         CMD_ADDSAT: begin
            if (ovf)
               result = a_q[M] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      status        = 3'd0;
      mem.mem_en    = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state)
         S_RD_A: begin
            status       = 3'd5;
            mem.mem_en   = 1'b1;
            mem.mem_addr = a_base + idx_w;
         end
         S_RD_B: begin
            status       = 3'd5;
            mem.mem_en   = 1'b1;
            mem.mem_addr = b_base + idx_w;
         end
         S_WR_R: begin
            status        = 3'd5;
            mem.mem_en    = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = r_base + idx_w;
            mem.mem_wdata = result;
         end
         S_DONE:  status = 3'd1;
         S_ERR:   status = 3'd6;
         default: status = 3'd0;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state   <= S_IDLE;
         cmd_q   <= CMD_NOP;
         a_base  <= '0;
         b_base  <= '0;
         r_base  <= '0;
         n_q     <= '0;
         idx     <= '0;
         a_q     <= '0;
         ovf_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd != CMD_NOP) begin
                  cmd_q   <= cmd;
                  a_base  <= veca_addr[ADDR_W-1:SH];
                  b_base  <= vecb_addr[ADDR_W-1:SH];
                  r_base  <= vecr_addr[ADDR_W-1:SH];
                  n_q     <= n_in;
                  idx     <= '0;
                  ovf_cnt <= '0;
`ifdef VEC_ALU_SAT_EN
                  if (n_in == '0)
                     state <= S_DONE;
                  else
                     state <= S_RD_A;
`else
                  if (cmd == CMD_ADDSAT)
                     state <= S_ERR;
                  else if (n_in == '0)
                     state <= S_DONE;
                  else
                     state <= S_RD_A;
`endif
               end
            end
            S_RD_A: state <= S_RD_B;
            S_RD_B: begin
               a_q   <= mem.mem_rdata;
               state <= S_WR_R;
            end
            S_WR_R: begin
               if (ovf && (ovf_cnt != '1))
                  ovf_cnt <= ovf_cnt + ADDR_W'(1);
               idx <= idx + NW'(1);
               if ((idx + NW'(1)) == n_q)
                  state <= S_DONE;
               else
                  state <= S_RD_A;
            end
            S_DONE, S_ERR: begin
               if (cmd == CMD_NOP)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vec_alu_engine.sv
// Directed self-checking bench for vec_alu_engine: a 32-bit instance for the main cases and a
// 16-bit instance for the in-place random vector; results follow VEC_ALU_SAT_EN when defined.
module tb_vec_alu_engine;
   logic ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   logic        ARESET;
   logic [1:0]  cmd, cmd16;
   logic [13:0] va, vb, vr, va16, vb16, vr16;
   logic [14:0] vl, vl16;
   logic [2:0]  status, status16;
   logic [13:0] ovf_cnt, ovf16;

   vec_alu_engine_if #(.DATA_W(32), .ADDR_W(14)) m32 ();
   vec_alu_engine_if #(.DATA_W(16), .ADDR_W(14)) m16 ();

   vec_alu_engine #(.DATA_W(32), .ADDR_W(14)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .cmd(cmd),
      .veca_addr(va), .vecb_addr(vb), .vecr_addr(vr), .vec_len(vl),
      .status(status), .ovf_cnt(ovf_cnt), .mem(m32)
   );

   vec_alu_engine #(.DATA_W(16), .ADDR_W(14)) dut16 (
      .ACLK(ACLK), .ARESET(ARESET), .cmd(cmd16),
      .veca_addr(va16), .vecb_addr(vb16), .vecr_addr(vr16), .vec_len(vl16),
      .status(status16), .ovf_cnt(ovf16), .mem(m16)
   );

   logic [31:0] mem32 [0:4095];
   logic [15:0] mem16 [0:8191];
   logic        pk_we, pk16_we;
   logic [11:0] pk_addr;
   logic [12:0] pk16_addr;
   logic [31:0] pk_data;
   logic [15:0] pk16_data;

   always @(posedge ACLK) begin
      if (pk_we) mem32[pk_addr] <= pk_data;
      else if (m32.mem_en) begin
         if (m32.mem_we) mem32[m32.mem_addr] <= m32.mem_wdata;
         else            m32.mem_rdata <= mem32[m32.mem_addr];
      end
   end

   always @(posedge ACLK) begin
      if (pk16_we) mem16[pk16_addr] <= pk16_data;
      else if (m16.mem_en) begin
         if (m16.mem_we) mem16[m16.mem_addr] <= m16.mem_wdata;
         else            m16.mem_rdata <= mem16[m16.mem_addr];
      end
   end

   int errors = 0;
   int checks = 0;
   int lat;
   logic any_en;
   logic [11:0] tr [0:63];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      pk_we = 1'b1; pk_addr = a; pk_data = d;
      @(negedge ACLK);
      pk_we = 1'b0;
   endtask

   task automatic poke16(input logic [12:0] a, input logic [15:0] d);
      pk16_we = 1'b1; pk16_addr = a; pk16_data = d;
      @(negedge ACLK);
      pk16_we = 1'b0;
   endtask

   // Runs one command; inputs are scrambled once the command is accepted to show they are ignored.
   task automatic run32(input string tag, input logic [1:0] c, input logic [13:0] a, b, r,
                        input logic [14:0] len, input logic [2:0] exp_st, input int exp_lat);
      cmd = c; va = a; vb = b; vr = r; vl = len; lat = 0; any_en = 1'b0;
      do begin
         @(negedge ACLK);
         lat++;
         if (lat == 1) begin
            va = 14'($urandom); vb = 14'($urandom); vr = 14'($urandom); vl = 15'($urandom);
         end
         if (lat < 64) tr[lat] = m32.mem_addr;
         if (m32.mem_en) any_en = 1'b1;
      end while (status == 3'd5 && lat < 200);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_status"}, 64'(status), 64'(exp_st));
      @(negedge ACLK);
      chk({tag, "_hold"}, 64'(status), 64'(exp_st));
      cmd = 2'd0;
      @(negedge ACLK);
      chk({tag, "_idle"}, 64'(status), 64'd0);
   endtask

   logic [15:0] ra [0:15];
   logic [15:0] rb [0:15];
   int exp_ovf16;

   initial begin
      ARESET = 1'b1; cmd = 2'd1; cmd16 = 2'd0;
      va = '0; vb = '0; vr = '0; vl = 15'd4;
      va16 = '0; vb16 = '0; vr16 = '0; vl16 = '0;
      pk_we = 1'b0; pk16_we = 1'b0; pk_addr = '0; pk_data = '0; pk16_addr = '0; pk16_data = '0;

      // reset state, with ADD held on cmd so reset must win
      repeat (3) @(negedge ACLK);
      chk("rst_status", 64'(status), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt), 64'd0);
      chk("rst_en", 64'(m32.mem_en), 64'd0);
      chk("rst_we", 64'(m32.mem_we), 64'd0);
      chk("rst_addr", 64'(m32.mem_addr), 64'd0);
      chk("rst_wdata", 64'(m32.mem_wdata), 64'd0);
      ARESET = 1'b0; cmd = 2'd0;
      @(negedge ACLK);

      // single element ADD: word1 + word2 -> word4
      poke(12'd1, 32'd16);
      poke(12'd2, 32'd32);
      run32("add1", 2'd1, 14'd4, 14'd8, 14'd16, 15'd4, 3'd1, 4);
      chk("add1_r", 64'(mem32[4]), 64'd48);
      chk("add1_ovf", 64'(ovf_cnt), 64'd0);

      // zero-length and partial-word-only lengths finish without memory access
      run32("len0", 2'd2, 14'd0, 14'd0, 14'd0, 15'd0, 3'd1, 1);
      chk("len0_noen", 64'(any_en), 64'd0);
      chk("len0_ovf", 64'(ovf_cnt), 64'd0);
      run32("len3", 2'd1, 14'd0, 14'd4, 14'd8, 15'd3, 3'd1, 1);
      chk("len3_noen", 64'(any_en), 64'd0);

      // signed overflow on ADD
      poke(12'd10, 32'h7FFF_FFFF);
      poke(12'd11, 32'h0000_0001);
      poke(12'd14, 32'h8000_0000);
      poke(12'd15, 32'hFFFF_FFFF);
      run32("addovf", 2'd1, 14'd40, 14'd44, 14'd48, 15'd4, 3'd1, 4);
      chk("addovf_r", 64'(mem32[12]), 64'h8000_0000);
      chk("addovf_cnt", 64'(ovf_cnt), 64'd1);
`ifdef VEC_ALU_SAT_EN
      run32("satpos", 2'd3, 14'd40, 14'd44, 14'd52, 15'd4, 3'd1, 4);
      chk("satpos_r", 64'(mem32[13]), 64'h7FFF_FFFF);
      chk("satpos_cnt", 64'(ovf_cnt), 64'd1);
      run32("satneg", 2'd3, 14'd56, 14'd60, 14'd64, 15'd4, 3'd1, 4);
      chk("satneg_r", 64'(mem32[16]), 64'h8000_0000);
      chk("satneg_cnt", 64'(ovf_cnt), 64'd1);
`else
      run32("saterr", 2'd3, 14'd40, 14'd44, 14'd52, 15'd4, 3'd6, 1);
      chk("saterr_noen", 64'(any_en), 64'd0);
      chk("saterr_ovf", 64'(ovf_cnt), 64'd0);
`endif

      // three-element SUB, two trailing bytes ignored
      poke(12'd20, 32'h8000_0000); poke(12'd21, 32'd5);  poke(12'd22, 32'd100);
      poke(12'd30, 32'd1);         poke(12'd31, 32'd7);  poke(12'd32, 32'd50);
      run32("sub3", 2'd2, 14'd80, 14'd120, 14'd160, 15'd14, 3'd1, 10);
      chk("sub3_r0", 64'(mem32[40]), 64'h7FFF_FFFF);
      chk("sub3_r1", 64'(mem32[41]), 64'hFFFF_FFFE);
      chk("sub3_r2", 64'(mem32[42]), 64'd50);
      chk("sub3_ovf", 64'(ovf_cnt), 64'd1);

      // A vector wraps from word 0xFFF to word 0
      poke(12'hFFF, 32'd3); poke(12'h000, 32'd4);
      poke(12'h040, 32'd10); poke(12'h041, 32'd20);
      run32("wrap", 2'd1, 14'h3FFC, 14'h0100, 14'h0200, 15'd8, 3'd1, 7);
      chk("wrap_rda0", 64'(tr[1]), 64'hFFF);
      chk("wrap_rda1", 64'(tr[4]), 64'h000);
      chk("wrap_r0", 64'(mem32[12'h080]), 64'd13);
      chk("wrap_r1", 64'(mem32[12'h081]), 64'd24);

      // reset in the middle of an 8-element ADD, then a clean rerun
      for (int i = 0; i < 8; i++) begin
         poke(12'(12'h100 + i), 32'(1000 * i + 1));
         poke(12'(12'h180 + i), 32'(3 * i));
      end
      cmd = 2'd1; va = 14'h0400; vb = 14'h0600; vr = 14'h0800; vl = 15'd32;
      repeat (4) @(negedge ACLK);
      chk("mid_busy", 64'(status), 64'd5);
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("mid_rst_status", 64'(status), 64'd0);
      chk("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
      chk("mid_rst_en", 64'(m32.mem_en), 64'd0);
      chk("mid_rst_we", 64'(m32.mem_we), 64'd0);
      chk("mid_rst_addr", 64'(m32.mem_addr), 64'd0);
      chk("mid_rst_wdata", 64'(m32.mem_wdata), 64'd0);
      ARESET = 1'b0; cmd = 2'd0;
      @(negedge ACLK);
      run32("rerun", 2'd1, 14'h0400, 14'h0600, 14'h0800, 15'd32, 3'd1, 25);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rerun_r%0d", i), 64'(mem32[12'h200 + i]), 64'(1003 * i + 1));
      chk("rerun_ovf", 64'(ovf_cnt), 64'd0);

      // 16-bit in-place ADD (R == A) against a signed model
      exp_ovf16 = 0;
      for (int i = 0; i < 16; i++) begin
         ra[i] = (i == 0) ? 16'h7FFF : 16'($urandom);
         rb[i] = (i == 0) ? 16'h0001 : 16'($urandom);
         poke16(13'(13'h100 + i), ra[i]);
         poke16(13'(13'h200 + i), rb[i]);
         if (($signed(ra[i]) + $signed(rb[i]) > 32767) || ($signed(ra[i]) + $signed(rb[i]) < -32768))
            exp_ovf16++;
      end
      cmd16 = 2'd1; va16 = 14'h0200; vb16 = 14'h0400; vr16 = 14'h0200; vl16 = 15'd32;
      lat = 0;
      do begin
         @(negedge ACLK);
         lat++;
      end while (status16 == 3'd5 && lat < 200);
      chk("inpl_latency", 64'(lat), 64'd49);
      chk("inpl_status", 64'(status16), 64'd1);
      cmd16 = 2'd0;
      @(negedge ACLK);
      for (int i = 0; i < 16; i++)
         chk($sformatf("inpl_r%0d", i), 64'(mem16[13'h100 + i]), 64'(16'(ra[i] + rb[i])));
      chk("inpl_ovf", 64'(ovf16), 64'(exp_ovf16));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
